shtp_tx_arbiter: RTL

//  Shares the single SHTP transmit byte path between NUM_REQ packet requesters (round-robin).
//  For each granted request it emits the 4-byte SHTP header, then streams the requester's payload.

---
 rtl/shtp_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/shtp_tx_arbiter.sv
// Round-robin arbiter sharing one SHTP transmit byte path: 4-byte header, then payload pass-through.
// Optional payload-stall timeout with zero padding is enabled by defining SHTP_TX_TIMEOUT_EN.
module shtp_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PAYLOAD = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [3*NUM_REQ-1:0]    req_channel,
  input  logic [15*NUM_REQ-1:0]   req_len,
  output logic [NUM_REQ-1:0]      req_grant,
  input  logic [8*NUM_REQ-1:0]    pl_data,
  input  logic [NUM_REQ-1:0]      pl_valid,
  output logic [NUM_REQ-1:0]      pl_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_first,
  output logic                    tx_last,
  output logic                    busy,
  output logic                    err_len,
  output logic                    err_timeout
);

  localparam int IDXW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HDR     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_PAD     = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("shtp_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_PAYLOAD < 0 || MAX_PAYLOAD > 32763) begin : g_bad_max_payload
    $error("shtp_tx_arbiter: MAX_PAYLOAD must be 0..32763");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("shtp_tx_arbiter: TIMEOUT_CYC must be >= 1");
  end

  logic [1:0]         state_q, state_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDXW-1:0]    gidx_q, gidx_d;
  logic [2:0]         ch_q, ch_d;
  logic [14:0]        len_q, len_d;
  logic [14:0]        rem_q, rem_d;
  logic [7:0]         seq_cur_q, seq_cur_d;
  logic [1:0]         idx_q, idx_d;
  logic               err_len_q, err_len_d;
  logic               seq_inc;
  logic [7:0]         seq_q [8];

  logic               found;
  logic [IDXW-1:0]    sel;
  logic [IDXW-1:0]    ptr_inc;
  logic [2:0]         sel_ch;
  logic [14:0]        sel_len;
  logic [15:0]        hdr_len;
  int                 cand;

`ifdef SHTP_TX_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_to_q, err_to_d;
`endif

  // First pending requester at or after the pointer, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = IDXW'(cand);
      end
    end
  end

  assign sel_ch  = req_channel[sel*3 +: 3];
  assign sel_len = req_len[sel*15 +: 15];
  assign ptr_inc = (sel == IDXW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  assign hdr_len = {1'b0, len_q + 15'd4};

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ch_d      = ch_q;
    len_d     = len_q;
    rem_d     = rem_q;
    seq_cur_d = seq_cur_q;
    idx_d     = idx_q;
    err_len_d = 1'b0;
    seq_inc   = 1'b0;
`ifdef SHTP_TX_TIMEOUT_EN
    stall_d   = stall_q;
    err_to_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        // A grant still showing (length-error pulse) blocks arbitration for that cycle.
        if (found && grant_q == '0) begin
          ptr_d        = ptr_inc;
          grant_d[sel] = 1'b1;
          if (sel_len > 15'(MAX_PAYLOAD)) begin
            err_len_d = 1'b1;
          end else begin
            state_d   = ST_HDR;
            gidx_d    = sel;
            ch_d      = sel_ch;
            len_d     = sel_len;
            rem_d     = sel_len;
            seq_cur_d = seq_q[sel_ch];
            idx_d     = '0;
`ifdef SHTP_TX_TIMEOUT_EN
            stall_d   = '0;
`endif
          end
        end
      end
      ST_HDR: begin
        if (tx_valid && tx_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (len_q == '0) begin
              state_d = ST_IDLE;
              grant_d = '0;
              seq_inc = 1'b1;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        if (tx_valid && tx_ready) begin
          rem_d = rem_q - 15'd1;
          if (rem_q == 15'd1) begin
            state_d = ST_IDLE;
            grant_d = '0;
            seq_inc = 1'b1;
          end
        end
`ifdef SHTP_TX_TIMEOUT_EN
        if (pl_valid[gidx_q]) begin
          if (tx_ready) stall_d = '0;
        end else if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
          stall_d  = '0;
          err_to_d = 1'b1;
          state_d  = ST_PAD;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
`ifdef SHTP_TX_TIMEOUT_EN
      ST_PAD: begin
        if (tx_ready) begin
          rem_d = rem_q - 15'd1;
          if (rem_q == 15'd1) begin
            state_d = ST_IDLE;
            grant_d = '0;
            seq_inc = 1'b1;
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the sequence table is tiny and must restart at 0, so it is reset like any register.
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      gidx_q    <= '0;
      ch_q      <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      seq_cur_q <= '0;
      idx_q     <= '0;
      err_len_q <= 1'b0;
      for (int i = 0; i < 8; i++) seq_q[i] <= '0;
`ifdef SHTP_TX_TIMEOUT_EN
      stall_q   <= '0;
      err_to_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ch_q      <= ch_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      seq_cur_q <= seq_cur_d;
      idx_q     <= idx_d;
      err_len_q <= err_len_d;
      if (seq_inc) seq_q[ch_q] <= seq_q[ch_q] + 8'd1;
`ifdef SHTP_TX_TIMEOUT_EN
      stall_q   <= stall_d;
      err_to_q  <= err_to_d;
`endif
    end
  end

  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    tx_first = 1'b0;
    tx_last  = 1'b0;
    pl_ready = '0;
    case (state_q)
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_first = (idx_q == 2'd0);
        tx_last  = (idx_q == 2'd3) && (len_q == '0);
        case (idx_q)
          2'd0:    tx_data = hdr_len[7:0];
          2'd1:    tx_data = hdr_len[15:8];
          2'd2:    tx_data = {5'd0, ch_q};
          default: tx_data = seq_cur_q;
        endcase
      end
      ST_PAYLOAD: begin
        tx_data  = pl_data[{gidx_q, 3'b000} +: 8];
        tx_valid = pl_valid[gidx_q];
        pl_ready = grant_q & {NUM_REQ{tx_ready}};
        tx_last  = (rem_q == 15'd1);
      end
`ifdef SHTP_TX_TIMEOUT_EN
      ST_PAD: begin
        tx_valid = 1'b1;
        tx_last  = (rem_q == 15'd1);
      end
`endif
      default: ;
    endcase
  end

  assign req_grant = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign err_len   = err_len_q;
`ifdef SHTP_TX_TIMEOUT_EN
  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule
